lookup_arbiter: RTL and testbench
=================================

# lookup_arbiter

Sequencer and two-way arbiter for the number-lookup datapath (4-bit number, selection, mode in; digit1/digit0/warning out). Two requesters share one lookup unit via a req/ack handshake; the block grants round-robin, issues one lookup strobe, waits for completion with a timeout, returns the result to the winner and keeps BCD hit and error counters.

## Interface
- TIMEOUT, 15: WAIT-state cycles without lk_done before abort (legal 2..255).
- CLK  in  1  clock, rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  request from requester 0/1; held high with stable fields until its ack.
- num0, num1  in  4  number to look up.
- sel0, sel1  in  1  selection field.
- mode0, mode1  in  1  mode field.
- ack0, ack1  out  1  one-cycle completion pulse to requester 0/1.
- rsp_digit1, rsp_digit0  out  8  result digits; valid while ack0 or ack1 is high.
- rsp_warning  out  1  result warning; valid with ack.
- lk_valid  out  1  one-cycle issue strobe to the lookup unit.
- lk_number  out  4; lk_selection, lk_mode  out  1  latched request fields; stable from lk_valid until ack.
- lk_done  in  1  lookup completion; lk_digit1, lk_digit0 (8), lk_warning (1) valid with it.
- busy  out  1  high in any state except IDLE.
- ok_cnt0, ok_cnt1  out  8  per-requester BCD successful lookups ([7:4] tens, [3:0] ones).
- err_cnt  out  8  shared BCD count of warning or timeout responses.
- to_flag  out  1  sticky, set on any timeout.

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE: if req0 or req1 high, grant. Only one requester high: grant it. Both high: grant the one not granted last (last_gnt resets to 1, so requester 0 wins the first tie). Latch num/sel/mode of the grantee into lk_* and go to ISSUE.
- ISSUE: lk_valid=1 for exactly this cycle; clear timer; go to WAIT.
- WAIT: lk_done sampled only here. lk_done=1: latch lk_digit1/lk_digit0/lk_warning into rsp_*, go to RESP. Otherwise, if timer==TIMEOUT-1: rsp_digit1=rsp_digit0=0, rsp_warning=1, set to_flag, go to RESP. Otherwise timer+1.
- RESP: ack of the granted requester high for this one cycle; update last_gnt; go to IDLE.
- Counters update on the WAIT→RESP edge:
  - If the result warning is 0, increment ok_cnt of the grantee.
  - Otherwise (including timeout), increment err_cnt.
- BCD increment: ones 9→0 with tens+1; 99→00 wrap; no saturation.
- lk_done outside WAIT (including the ISSUE cycle) is ignored.
- A req dropped before ack is a protocol violation. The block still completes and acks the latched grantee.

## Timing
- All outputs registered. Reset values: every output 0; state IDLE, timer 0, last_gnt 1.
- Asynchronous reset mid-operation: immediate return to IDLE, lk_valid/ack drop, no ack issued, counters and to_flag cleared.
- Latency: req seen at edge N → lk_valid high in cycle N+1 → earliest lk_done sampled at edge N+2 → ack high in cycle N+3. General case: ack 3+k cycles after the grant edge, where k = extra WAIT cycles, k ≤ TIMEOUT-1.
- Timeout: ack follows the edge that ends the TIMEOUT-th WAIT cycle.
- After ack the requester drops req on the next edge. IDLE samples req one edge later, so there is no double grant. The minimum gap between consecutive lk_valid strobes is 4 cycles.
- Simultaneous lk_done and timer==TIMEOUT-1: lk_done wins; no timeout, to_flag unchanged.

## Test plan
- Reset: clear_n low mid-WAIT → all outputs 0, busy 0. Release, req0 num0=5 sel0=0 mode0=1, model returns digit1=7 digit0=5 warning=0 in the first WAIT cycle → ack0 3 cycles after grant, rsp 7/5/0, ok_cnt0=0x01.
- Tie: req0 and req1 raised together, both held → order of acks is 0,1,0,1; lk_number alternates num0/num1.
- Warning path: model returns lk_warning=1 → rsp_warning=1, err_cnt +1, ok_cnt unchanged.
- Timeout: TIMEOUT=15, model never asserts lk_done → ack after 15 WAIT cycles, rsp 0/0/1, to_flag=1 sticky across later good lookups.
- Race: lk_done in the ISSUE cycle ignored; lk_done on the last WAIT cycle → normal response, to_flag stays 0.
- BCD wrap: 100 successful req1 lookups → ok_cnt1 passes 0x09→0x10 and ends at 0x00.

Source files
------------

// File: rtl/lookup_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : lookup_arbiter_if
//  Purpose  : Requester handshake and lookup-unit bus bundle for
//             lookup_arbiter. The arbiter uses the slave view. The
//             surrounding environment uses the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface lookup_arbiter_if;
    // requester side
    logic       req0, req1;
    logic [3:0] num0, num1;
    logic       sel0, sel1;
    logic       mode0, mode1;
    logic       ack0, ack1;
    logic [7:0] rsp_digit1, rsp_digit0;
    logic       rsp_warning;
    // lookup-unit side
    logic       lk_valid;
    logic [3:0] lk_number;
    logic       lk_selection, lk_mode;
    logic       lk_done;
    logic [7:0] lk_digit1, lk_digit0;
    logic       lk_warning;

    modport slave (
        input  req0, req1, num0, num1, sel0, sel1, mode0, mode1,
        output ack0, ack1, rsp_digit1, rsp_digit0, rsp_warning,
        output lk_valid, lk_number, lk_selection, lk_mode,
        input  lk_done, lk_digit1, lk_digit0, lk_warning
    );

    modport master (
        output req0, req1, num0, num1, sel0, sel1, mode0, mode1,
        input  ack0, ack1, rsp_digit1, rsp_digit0, rsp_warning,
        input  lk_valid, lk_number, lk_selection, lk_mode,
        output lk_done, lk_digit1, lk_digit0, lk_warning
    );
endinterface
`default_nettype wire

// File: rtl/lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lookup_arbiter
//  Purpose  : Round-robin two-way arbiter and sequencer for the shared
//             number-lookup unit. It issues one strobe per grant and waits
//             for completion with a timeout. It returns the result to the
//             winner and keeps BCD hit and error counters.
//  Revision : 1.0  initial release
// ============================================================================
module lookup_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            clear_n,
    lookup_arbiter_if.slave bus,
    output logic            busy,
    output logic [7:0]      ok_cnt0,
    output logic [7:0]      ok_cnt1,
    output logic [7:0]      err_cnt,
    output logic            to_flag
);

    localparam logic [7:0] C_TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_gnt, w_gnt_nxt;
    logic       r_last_gnt;
    logic [7:0] r_timer;
    logic       w_done, w_timeout, w_finish;

    logic       r_ack0, r_ack1, r_lk_valid, r_busy, r_to_flag;
    logic [3:0] r_lk_number;
    logic       r_lk_selection, r_lk_mode;
    logic [7:0] r_rsp_digit1, r_rsp_digit0;
    logic       r_rsp_warning;
    logic [7:0] r_ok_cnt0, r_ok_cnt1, r_err_cnt;

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] res;
        if (v[3:0] == 4'd9) begin
            res[3:0] = 4'd0;
            res[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            res = {v[7:4], v[3:0] + 4'd1};
        end
        return res;
    endfunction

    // State register.
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state, grant decision and WAIT completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_state_nxt = S_ISSUE;
                    // On a tie the requester not served last wins.
                    if (bus.req0 && bus.req1) w_gnt_nxt = ~r_last_gnt;
                    else                      w_gnt_nxt = bus.req1;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A completion on the last timer cycle beats the timeout.
                if (bus.lk_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_timer == C_TIMER_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_finish = w_done | w_timeout;

    // Registered datapath: grant latch, strobes, timer, response and counters.
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            r_gnt          <= 1'b0;
            r_last_gnt     <= 1'b1;
            r_timer        <= 8'd0;
            r_ack0         <= 1'b0;
            r_ack1         <= 1'b0;
            r_lk_valid     <= 1'b0;
            r_busy         <= 1'b0;
            r_to_flag      <= 1'b0;
            r_lk_number    <= 4'd0;
            r_lk_selection <= 1'b0;
            r_lk_mode      <= 1'b0;
            r_rsp_digit1   <= 8'd0;
            r_rsp_digit0   <= 8'd0;
            r_rsp_warning  <= 1'b0;
            r_ok_cnt0      <= 8'd0;
            r_ok_cnt1      <= 8'd0;
            r_err_cnt      <= 8'd0;
        end else begin
            r_lk_valid <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_busy     <= (w_state_nxt != S_IDLE);

            if (r_state == S_IDLE && w_state_nxt == S_ISSUE) begin
                r_gnt          <= w_gnt_nxt;
                r_lk_valid     <= 1'b1;
                r_lk_number    <= w_gnt_nxt ? bus.num1  : bus.num0;
                r_lk_selection <= w_gnt_nxt ? bus.sel1  : bus.sel0;
                r_lk_mode      <= w_gnt_nxt ? bus.mode1 : bus.mode0;
            end

            if (r_state == S_ISSUE) r_timer <= 8'd0;
            else if (r_state == S_WAIT && !w_finish) r_timer <= r_timer + 8'd1;

            if (w_finish) begin
                r_ack0 <= ~r_gnt;
                r_ack1 <= r_gnt;
                if (w_done) begin
                    r_rsp_digit1  <= bus.lk_digit1;
                    r_rsp_digit0  <= bus.lk_digit0;
                    r_rsp_warning <= bus.lk_warning;
                end else begin
                    r_rsp_digit1  <= 8'd0;
                    r_rsp_digit0  <= 8'd0;
                    r_rsp_warning <= 1'b1;
                    r_to_flag     <= 1'b1;
                end
                if (w_done && !bus.lk_warning) begin
                    if (r_gnt) r_ok_cnt1 <= bcd_inc(r_ok_cnt1);
                    else       r_ok_cnt0 <= bcd_inc(r_ok_cnt0);
                end else begin
                    r_err_cnt <= bcd_inc(r_err_cnt);
                end
            end

            if (r_state == S_RESP) r_last_gnt <= r_gnt;
        end
    end

    assign bus.ack0         = r_ack0;
    assign bus.ack1         = r_ack1;
    assign bus.rsp_digit1   = r_rsp_digit1;
    assign bus.rsp_digit0   = r_rsp_digit0;
    assign bus.rsp_warning  = r_rsp_warning;
    assign bus.lk_valid     = r_lk_valid;
    assign bus.lk_number    = r_lk_number;
    assign bus.lk_selection = r_lk_selection;
    assign bus.lk_mode      = r_lk_mode;
    assign busy             = r_busy;
    assign ok_cnt0          = r_ok_cnt0;
    assign ok_cnt1          = r_ok_cnt1;
    assign err_cnt          = r_err_cnt;
    assign to_flag          = r_to_flag;

endmodule
`default_nettype wire

// File: tb/tb_lookup_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lookup_arbiter
//  Purpose  : Self-checking bench for lookup_arbiter with a transaction-level
//             reference model of arbitration, timing, results and counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lookup_arbiter;

    localparam int TIMEOUT = 15;

    logic       CLK = 1'b0;
    logic       clear_n;
    logic       busy;
    logic [7:0] ok_cnt0, ok_cnt1, err_cnt;
    logic       to_flag;

    lookup_arbiter_if bus();

    lookup_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK     (CLK),
        .clear_n (clear_n),
        .bus     (bus),
        .busy    (busy),
        .ok_cnt0 (ok_cnt0),
        .ok_cnt1 (ok_cnt1),
        .err_cnt (err_cnt),
        .to_flag (to_flag)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    int         m_last = 1;
    int         m_ok[2];
    int         m_err  = 0;
    bit         m_to   = 1'b0;
    bit         pend[2];
    logic [3:0] pnum[2];
    bit         psel[2], pmode[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // decimal count -> two BCD digits
    function automatic logic [7:0] bcd(input int n);
        int v;
        v = n % 100;
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_reqs;
        bus.req0  = pend[0]; bus.num0 = pnum[0]; bus.sel0 = psel[0]; bus.mode0 = pmode[0];
        bus.req1  = pend[1]; bus.num1 = pnum[1]; bus.sel1 = psel[1]; bus.mode1 = pmode[1];
    endtask

    task automatic raise(input int r, input logic [3:0] n, input bit s, input bit m);
        if (!pend[r]) begin
            pend[r] = 1'b1; pnum[r] = n; psel[r] = s; pmode[r] = m;
        end
        drive_reqs();
    endtask

    task automatic raise_rand(input int r);
        raise(r, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic model_reset;
        m_last = 1; m_ok[0] = 0; m_ok[1] = 0; m_err = 0; m_to = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_reqs();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_ok0"}, ok_cnt0, bcd(m_ok[0]));
        check({tag, "_ok1"}, ok_cnt1, bcd(m_ok[1]));
        check({tag, "_err"}, err_cnt, bcd(m_err));
        check({tag, "_to"},  to_flag, m_to);
    endtask

    // One transaction starting in an IDLE cycle with at least one request
    // pending. k = WAIT cycle carrying lk_done (k < 0: never, timeout).
    task automatic run_txn(input int k, input bit warn, input logic [7:0] d1,
                           input logic [7:0] d0, input bit spur, input bit viol,
                           output int obs_g);
        int  g;
        bit  acked;
        if (pend[0] && pend[1]) g = 1 - m_last;
        else if (pend[1])       g = 1;
        else                    g = 0;

        tick; // grant edge
        check("lk_valid", bus.lk_valid, 1);
        check("lk_fields", {bus.lk_number, bus.lk_selection, bus.lk_mode},
              {pnum[g], psel[g], pmode[g]});
        check("busy_issue", busy, 1);
        if (spur) begin
            bus.lk_done = 1'b1; bus.lk_digit1 = 8'hEE; bus.lk_digit0 = 8'hDD; bus.lk_warning = 1'b1;
        end
        tick; // ISSUE -> WAIT
        bus.lk_done = 1'b0;
        check("lk_valid_once", bus.lk_valid, 0);
        if (viol) begin
            pend[g] = 1'b0;
            drive_reqs();
        end

        acked = 1'b0;
        for (int i = 0; i < TIMEOUT && !acked; i++) begin
            if (i == k) begin
                bus.lk_done = 1'b1; bus.lk_digit1 = d1; bus.lk_digit0 = d0; bus.lk_warning = warn;
            end
            tick;
            bus.lk_done = 1'b0;
            if (i == k || (k < 0 && i == TIMEOUT - 1)) acked = 1'b1;
            else check("no_early_ack", {bus.ack1, bus.ack0}, 2'b00);
        end

        if (k < 0) begin
            m_err++; m_to = 1'b1;
            check("rsp", {bus.rsp_digit1, bus.rsp_digit0, bus.rsp_warning}, {8'd0, 8'd0, 1'b1});
        end else begin
            if (warn) m_err++;
            else      m_ok[g]++;
            check("rsp", {bus.rsp_digit1, bus.rsp_digit0, bus.rsp_warning}, {d1, d0, warn});
        end
        check("ack", {bus.ack1, bus.ack0}, (g == 1) ? 2'b10 : 2'b01);
        check_counters("cnt");
        obs_g = bus.ack1 ? 1 : 0;

        m_last  = g;
        pend[g] = 1'b0;
        drive_reqs();
        tick; // RESP -> IDLE
        check("ack_pulse", {bus.ack1, bus.ack0}, 2'b00);
        check("busy_idle", busy, 0);
    endtask

    task automatic rand_txn(input int r_only);
        int sel, k, og;
        if (r_only >= 0) begin
            raise_rand(r_only);
        end else begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 1) == 1) raise_rand(r);
            if (!pend[0] && !pend[1]) raise_rand(int'($urandom_range(0, 1)));
        end
        sel = int'($urandom_range(0, 9));
        if (r_only >= 0)  k = int'($urandom_range(0, 3));
        else if (sel == 0) k = -1;
        else if (sel == 1) k = TIMEOUT - 1;
        else               k = int'($urandom_range(0, 3));
        run_txn(k, (r_only >= 0) ? 1'b0 : ($urandom_range(0, 3) == 0),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0), og);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int og;
        m_ok[0] = 0; m_ok[1] = 0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        pnum[0] = 4'd0; pnum[1] = 4'd0;
        psel[0] = 1'b0; psel[1] = 1'b0; pmode[0] = 1'b0; pmode[1] = 1'b0;
        drive_reqs();
        bus.lk_done = 1'b0; bus.lk_digit1 = 8'd0; bus.lk_digit0 = 8'd0; bus.lk_warning = 1'b0;
        clear_n = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ctrl", {bus.lk_valid, bus.ack0, bus.ack1, busy, to_flag}, 5'd0);
        check("rst_cnt", {ok_cnt0, ok_cnt1, err_cnt}, 24'd0);
        check("rst_data", {bus.rsp_digit1, bus.rsp_digit0, bus.rsp_warning,
                           bus.lk_number, bus.lk_selection, bus.lk_mode}, 23'd0);
        clear_n = 1'b1;
        tick;

        // directed first lookup, then the warning path on requester 1
        raise(0, 4'd5, 1'b0, 1'b1);
        run_txn(0, 1'b0, 8'd7, 8'd5, 1'b0, 1'b0, og);
        raise(1, 4'd9, 1'b1, 1'b0);
        run_txn(1, 1'b1, 8'd3, 8'd2, 1'b0, 1'b0, og);

        // tie with both requesters held: alternating grants starting at 0
        raise(0, 4'd3, 1'b1, 1'b1);
        raise(1, 4'd12, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            raise(0, 4'd3, 1'b1, 1'b1);
            raise(1, 4'd12, 1'b0, 1'b1);
            run_txn(int'($urandom_range(0, 2)), 1'b0, 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 1'b0, 1'b0, og);
            check("tie_order", og, i % 2);
        end

        // race: spurious done in ISSUE, real done on last WAIT cycle
        raise(1, 4'd6, 1'b0, 1'b0);
        run_txn(TIMEOUT - 1, 1'b0, 8'h42, 8'h17, 1'b1, 1'b0, og);
        check("race_no_to", to_flag, 0);

        // timeout, then sticky flag across good lookups
        raise(0, 4'd1, 1'b1, 1'b0);
        run_txn(-1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, og);
        for (int i = 0; i < 3; i++) rand_txn(i % 2);

        // randomized traffic
        for (int i = 0; i < 120; i++) rand_txn(-1);

        // asynchronous reset in the middle of WAIT
        raise(0, 4'd8, 1'b0, 1'b1);
        tick; tick; tick; tick;
        #2 clear_n = 1'b0;
        #1;
        check("midrst_ctrl", {bus.lk_valid, bus.ack0, bus.ack1, busy, to_flag}, 5'd0);
        check("midrst_cnt", {ok_cnt0, ok_cnt1, err_cnt}, 24'd0);
        model_reset();
        tick;
        clear_n = 1'b1;
        tick;

        // BCD wrap: 100 successful requester-1 lookups
        for (int i = 0; i < 100; i++) begin
            rand_txn(1);
            if (i == 8)  check("bcd_09", ok_cnt1, 8'h09);
            if (i == 9)  check("bcd_10", ok_cnt1, 8'h10);
        end
        check("bcd_wrap", ok_cnt1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
